// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types: word/line widths and the arbiter state encoding.
package lc3b_types;

    localparam int LC3B_ADDR_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arbiter_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serializes I-cache fills and D-cache fills/write-backs onto one physical memory port.
// state   | meaning
// IDLE    | no transaction; grant taken at end of cycle if any request is present
// SERVE_I | I-cache fill in flight, mem_read held until mem_resp
// SERVE_D | D-cache fill or write-back in flight, strobe held until mem_resp
// RELEASE | strobes low for one cycle so the requester can drop its request
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = LC3B_ADDR_W,
    parameter int LINE_W = LC3B_LINE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arbiter_state_t r_state;
    arbiter_state_t w_next_state;
    logic           r_last_grant;
    logic           w_d_req;
    logic           w_grant_i;
    logic           w_grant_d;

    assign w_d_req   = d_pmem_read | d_pmem_write;
    // Contested: favour whichever port did not win last time (last_grant 0 = I).
    assign w_grant_d = (r_state == IDLE) & w_d_req & (~i_pmem_read | ~r_last_grant);
    assign w_grant_i = (r_state == IDLE) & i_pmem_read & ~w_grant_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next_state = SERVE_D;
                else if (w_grant_i) w_next_state = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) w_next_state = RELEASE;
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        i_pmem_resp  = mem_resp & (r_state == SERVE_I);
        d_pmem_resp  = mem_resp & (r_state == SERVE_D);
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
    end

    // Write wins if the D-cache illegally raises read and write together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else if (w_grant_d) begin
            r_last_grant <= 1'b1;
            mem_read     <= ~d_pmem_write;
            mem_write    <= d_pmem_write;
            mem_address  <= d_pmem_address;
            mem_wdata    <= d_pmem_wdata;
        end else if (w_grant_i) begin
            r_last_grant <= 1'b0;
            mem_read     <= 1'b1;
            mem_write    <= 1'b0;
            mem_address  <= i_pmem_address;
        end else if ((r_state == SERVE_I || r_state == SERVE_D) && mem_resp) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change and outputs are checked on the falling edge.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;

    int total = 0;
    int bad   = 0;
    int i_cnt = 0;
    int d_cnt = 0;

    cache_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_pmem_resp) i_cnt++;
        if (d_pmem_resp) d_cnt++;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
        repeat (2) @(negedge clk);
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        total++; if (mem_address !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_address); end
        total++; if (mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lone_i();
        int i0 = i_cnt;
        int d0 = d_cnt;
        i_pmem_read = 1; i_pmem_address = 16'h1230;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL lone_i_strobe c%0d: got r%b w%b want r1 w0", c, mem_read, mem_write); end
            total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL lone_i_early_resp c%0d: got %b want 0", c, i_pmem_resp); end
        end
        total++; if (mem_address !== 16'h1230) begin bad++; $display("FAIL lone_i_addr: got %h want 1230", mem_address); end
        @(negedge clk);
        mem_rdata = {16{8'hA5}}; mem_resp = 1;
        #1;
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL lone_i_strobe c4: got %b want 1", mem_read); end
        total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL lone_i_resp: got %b want 1", i_pmem_resp); end
        total++; if (i_pmem_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL lone_i_rdata: got %h want a5..a5", i_pmem_rdata); end
        total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL lone_i_d_resp: got %b want 0", d_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; i_pmem_read = 0;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL lone_i_release: got %b want 0", mem_read); end
        @(negedge clk);
        total++; if (i_cnt - i0 !== 1 || d_cnt - d0 !== 0) begin bad++; $display("FAIL lone_i_counts: got i%0d d%0d want i1 d0", i_cnt - i0, d_cnt - d0); end
    endtask

    task automatic test_lone_d_write();
        int i0 = i_cnt;
        int d0 = d_cnt;
        d_pmem_write = 1; d_pmem_address = 16'h4000; d_pmem_wdata = {8{16'h1111}};
        @(negedge clk);
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL dwb_strobe: got r%b w%b want r0 w1", mem_read, mem_write); end
        total++; if (mem_address !== 16'h4000) begin bad++; $display("FAIL dwb_addr: got %h want 4000", mem_address); end
        total++; if (mem_wdata !== {8{16'h1111}}) begin bad++; $display("FAIL dwb_wdata: got %h want 1111..", mem_wdata); end
        @(negedge clk);
        mem_resp = 1;
        #1;
        total++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL dwb_resp: got d%b i%b want d1 i0", d_pmem_resp, i_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; d_pmem_write = 0;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL dwb_release: got %b want 0", mem_write); end
        @(negedge clk);
        total++; if (i_cnt - i0 !== 0 || d_cnt - d0 !== 1) begin bad++; $display("FAIL dwb_counts: got i%0d d%0d want i0 d1", i_cnt - i0, d_cnt - d0); end
    endtask

    task automatic test_contested();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h2200;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h2200) begin bad++; $display("FAIL contest_first: got r%b a%h want r1 a2200", mem_read, mem_address); end
        @(negedge clk);
        mem_rdata = {4{32'hDEAD_BEEF}}; mem_resp = 1;
        #1;
        total++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL contest_d_resp: got d%b i%b want d1 i0", d_pmem_resp, i_pmem_resp); end
        total++; if (d_pmem_rdata !== {4{32'hDEAD_BEEF}}) begin bad++; $display("FAIL contest_d_rdata: got %h want deadbeef..", d_pmem_rdata); end
        @(negedge clk);
        mem_resp = 0; d_pmem_read = 0;
        total++; if (mem_read !== 1'b0 || mem_address !== 16'h2200) begin bad++; $display("FAIL contest_release: got r%b a%h want r0 a2200", mem_read, mem_address); end
        @(negedge clk);
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL contest_idle_gap: got %b want 0", mem_read); end
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h0100) begin bad++; $display("FAIL contest_second: got r%b a%h want r1 a0100", mem_read, mem_address); end
        mem_resp = 1;
        #1;
        total++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL contest_i_resp: got i%b d%b want i1 d0", i_pmem_resp, d_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; i_pmem_read = 0;
        @(negedge clk);
        i_pmem_read = 1; i_pmem_address = 16'h0500;
        d_pmem_read = 1; d_pmem_address = 16'h3300;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h3300) begin bad++; $display("FAIL contest_again_d: got r%b a%h want r1 a3300", mem_read, mem_address); end
        mem_resp = 1;
        #1;
        total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL contest_again_resp: got %b want 1", d_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; d_pmem_read = 0; i_pmem_read = 0;
        @(negedge clk);
    endtask

    task automatic test_held();
        int i0 = i_cnt;
        int d0 = d_cnt;
        i_pmem_read = 1; i_pmem_address = 16'h0600;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h0600) begin bad++; $display("FAIL held_i_grant: got r%b a%h want r1 a0600", mem_read, mem_address); end
        d_pmem_read = 1; d_pmem_address = 16'h7700;
        @(negedge clk);
        mem_resp = 1;
        #1;
        total++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL held_i_resp: got i%b d%b want i1 d0", i_pmem_resp, d_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; i_pmem_read = 0;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL held_release: got %b want 0", mem_read); end
        @(negedge clk);
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL held_idle: got %b want 0", mem_read); end
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h7700) begin bad++; $display("FAIL held_d_grant: got r%b a%h want r1 a7700", mem_read, mem_address); end
        mem_resp = 1;
        #1;
        total++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL held_d_resp: got d%b i%b want d1 i0", d_pmem_resp, i_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; d_pmem_read = 0;
        @(negedge clk);
        total++; if (i_cnt - i0 !== 1 || d_cnt - d0 !== 1) begin bad++; $display("FAIL held_counts: got i%0d d%0d want i1 d1", i_cnt - i0, d_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        d_pmem_write = 1; d_pmem_address = 16'h5550; d_pmem_wdata = {8{16'hC3C3}};
        @(negedge clk);
        total++; if (mem_write !== 1'b1 || mem_address !== 16'h5550) begin bad++; $display("FAIL rmid_grant: got w%b a%h want w1 a5550", mem_write, mem_address); end
        @(negedge clk);
        mem_resp = 1;
        #1;
        total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL rmid_pre_resp: got %b want 1", d_pmem_resp); end
        #1;
        reset_n = 0; d_pmem_write = 0;
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rmid_write: got %b want 0", mem_write); end
        total++; if (mem_address !== 16'h0 || mem_wdata !== 128'h0) begin bad++; $display("FAIL rmid_data: got a%h w%h want 0", mem_address, mem_wdata); end
        total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL rmid_resp: got %b want 0", d_pmem_resp); end
        mem_resp = 0;
        @(negedge clk);
        reset_n = 1;
        i_pmem_read = 1; i_pmem_address = 16'h0A00;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h0A00) begin bad++; $display("FAIL rmid_new_grant: got r%b a%h want r1 a0a00", mem_read, mem_address); end
        mem_resp = 1;
        #1;
        total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL rmid_new_resp: got %b want 1", i_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; i_pmem_read = 0;
        @(negedge clk);
    endtask

    task automatic test_stray();
        mem_resp = 1;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL stray_idle_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        mem_resp = 0;
        total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL stray_idle_state: got %b want 00", {mem_read, mem_write}); end
        d_pmem_read = 1; d_pmem_address = 16'h0B00;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h0B00) begin bad++; $display("FAIL stray_d_grant: got r%b a%h want r1 a0b00", mem_read, mem_address); end
        mem_resp = 1;
        @(negedge clk);
        d_pmem_read = 0;
        #1;
        total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL stray_release_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
        @(negedge clk);
        mem_resp = 0;
        i_pmem_read = 1; i_pmem_address = 16'h0C00;
        @(negedge clk);
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h0C00) begin bad++; $display("FAIL stray_after_grant: got r%b a%h want r1 a0c00", mem_read, mem_address); end
        mem_resp = 1;
        #1;
        total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL stray_after_resp: got %b want 1", i_pmem_resp); end
        @(negedge clk);
        mem_resp = 0; i_pmem_read = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_i();
        test_lone_d_write();
        test_contested();
        test_held();
        test_reset_mid();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
